// File: rtl/mem_stage_ctrl.sv
// MIPS memory-stage controller: data-memory req/ack handshake, pipeline stall,
// branch resolution and MEM/WB registers. Optional access timeout via MEM_TIMEOUT_EN.
module mem_stage_ctrl
`ifdef MEM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_MemWrite_In,
  input  logic        MEM_MemRead_In,
  input  logic        MEM_MemtoReg_In,
  input  logic        MEM_RegWrite_In,
  input  logic        MEM_Zero_In,
  input  logic [1:0]  MEM_Branch_In,
  input  logic [31:0] MEM_ALUresult_In,
  input  logic [31:0] MEM_ReadData2_In,
  input  logic [4:0]  MEM_WriteRegister_In,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        PCSrc,
  output logic        WB_RegWrite_Out,
  output logic        WB_MemtoReg_Out,
  output logic [31:0] WB_ReadData_Out,
  output logic [31:0] WB_ALUresult_Out,
  output logic [4:0]  WB_WriteRegister_Out,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        mem_op;
  logic        req_d, we_d;
  logic [31:0] addr_d, wdata_d;
  logic [31:0] data_q, data_d;
  logic        wb_rw_d, wb_m2r_d;
  logic [31:0] wb_rd_d, wb_alu_d;
  logic [4:0]  wb_dst_d;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC) > 5) ? $clog2(TIMEOUT_CYC) : 5;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  // Write wins when both read and write are flagged.
  assign mem_op = MEM_MemRead_In | MEM_MemWrite_In;
  assign stall  = ((state_q == IDLE) && mem_op) || (state_q == ACCESS);
  assign PCSrc  = ((MEM_Branch_In == 2'b01) &&  MEM_Zero_In) ||
                  ((MEM_Branch_In == 2'b10) && !MEM_Zero_In);

  always_comb begin
    state_d  = state_q;
    req_d    = dmem_req;
    we_d     = dmem_we;
    addr_d   = dmem_addr;
    wdata_d  = dmem_wdata;
    data_d   = data_q;
    wb_rw_d  = WB_RegWrite_Out;
    wb_m2r_d = WB_MemtoReg_Out;
    wb_rd_d  = WB_ReadData_Out;
    wb_alu_d = WB_ALUresult_Out;
    wb_dst_d = WB_WriteRegister_Out;
`ifdef MEM_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d  = ACCESS;
          req_d    = 1'b1;
          we_d     = MEM_MemWrite_In;
          addr_d   = MEM_ALUresult_In;
          wdata_d  = MEM_ReadData2_In;
          wb_rw_d  = 1'b0;
          wb_m2r_d = 1'b0;
          wb_rd_d  = 32'd0;
          wb_alu_d = 32'd0;
          wb_dst_d = 5'd0;
`ifdef MEM_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end else begin
          wb_rw_d  = MEM_RegWrite_In;
          wb_m2r_d = MEM_MemtoReg_In;
          wb_rd_d  = 32'd0;
          wb_alu_d = MEM_ALUresult_In;
          wb_dst_d = MEM_WriteRegister_In;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          data_d  = dmem_we ? 32'd0 : dmem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        // Ack on the last allowed cycle takes priority over the abort.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          data_d  = dmem_we ? 32'd0 : ERR_DATA;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        wb_rw_d  = MEM_RegWrite_In;
        wb_m2r_d = MEM_MemtoReg_In;
        wb_rd_d  = data_q;
        wb_alu_d = MEM_ALUresult_In;
        wb_dst_d = MEM_WriteRegister_In;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q              <= IDLE;
      dmem_req             <= 1'b0;
      dmem_we              <= 1'b0;
      dmem_addr            <= 32'd0;
      dmem_wdata           <= 32'd0;
      data_q               <= 32'd0;
      WB_RegWrite_Out      <= 1'b0;
      WB_MemtoReg_Out      <= 1'b0;
      WB_ReadData_Out      <= 32'd0;
      WB_ALUresult_Out     <= 32'd0;
      WB_WriteRegister_Out <= 5'd0;
    end else begin
      state_q              <= state_d;
      dmem_req             <= req_d;
      dmem_we              <= we_d;
      dmem_addr            <= addr_d;
      dmem_wdata           <= wdata_d;
      data_q               <= data_d;
      WB_RegWrite_Out      <= wb_rw_d;
      WB_MemtoReg_Out      <= wb_m2r_d;
      WB_ReadData_Out      <= wb_rd_d;
      WB_ALUresult_Out     <= wb_alu_d;
      WB_WriteRegister_Out <= wb_dst_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller of the MIPS pipeline: consumes the EX/MEM register outputs, runs a req/ack handshake with an external data memory, stalls the front of the pipeline while an access is outstanding, resolves branches, and registers the MEM/WB stage outputs. It sits between the EX/MEM register and the register-file write-back mux, and drives the PC-source select and the global stall line.

## Interface
- TIMEOUT_CYC, 16: max ACCESS cycles without ack before abort (MEM_TIMEOUT_EN only)
- ERR_DATA, 32'hDEADBEEF: load data returned on timeout abort
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- MEM_MemWrite_In, MEM_MemRead_In, MEM_MemtoReg_In, MEM_RegWrite_In, MEM_Zero_In  in  1 each  EX/MEM control and ALU zero
- MEM_Branch_In  in  2  01 = beq, 10 = bne, 00/11 = no branch
- MEM_ALUresult_In  in  32  byte address / ALU result
- MEM_ReadData2_In  in  32  store data
- MEM_WriteRegister_In  in  5  destination register
- dmem_req  out  1  access request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  32  registered address
- dmem_wdata  out  32  registered store data
- dmem_rdata  in  32  load data, valid with dmem_ack
- dmem_ack  in  1  access complete, single-cycle pulse
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
- PCSrc  out  1  branch taken (combinational)
- WB_RegWrite_Out, WB_MemtoReg_Out  out  1 each  registered control
- WB_ReadData_Out  out  32  registered load data
- WB_ALUresult_Out  out  32  registered ALU result
- WB_WriteRegister_Out  out  5  registered destination
- mem_err  out  1  sticky timeout flag

## Operation
- mem_op = MEM_MemRead_In | MEM_MemWrite_In; both set -> write (write wins).
- FSM states IDLE, ACCESS, DONE.
- IDLE: mem_op=0 -> stay, WB regs load inputs, WB_ReadData_Out <= 0. mem_op=1 -> ACCESS; latch dmem_addr=ALUresult, dmem_wdata=ReadData2, dmem_we=MemWrite, dmem_req<=1; WB loads bubble (RegWrite=0, MemtoReg=0, others 0).
- ACCESS: hold dmem_req/addr/we/wdata; WB holds. dmem_ack -> capture rdata (0 for writes) into data reg, dmem_req<=0, -> DONE.
- DONE: WB regs load EX/MEM control, ALUresult, destination, captured data; -> IDLE.
- stall = (IDLE & mem_op) | ACCESS. Deasserted in DONE so EX/MEM advances on the same edge WB loads.
- dmem_ack outside ACCESS ignored.
- PCSrc = (Branch==01 & Zero) | (Branch==10 & ~Zero); independent of FSM.
- Address passed unmodified; no alignment check.

## Timing
- Reset (async, immediate): state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, all WB_* = 0, mem_err=0, counter 0.
- Non-memory instruction: WB outputs valid 1 cycle after EX/MEM presents it, no stall.
- Memory op with ack in first ACCESS cycle: stall high 2 cycles, WB valid 3 edges after presentation; each extra ack-wait cycle adds 1.
- Reset mid-ACCESS: dmem_req drops asynchronously; in-flight access abandoned, late ack ignored.
- Back-to-back memory ops: DONE -> IDLE then next op detected in IDLE; no overlap.

## Configuration
- MEM_TIMEOUT_EN defined: 5-bit-minimum counter clears on ACCESS entry, increments each ACCESS cycle without ack; when count reaches TIMEOUT_CYC-1 with no ack, dmem_req<=0, captured data = ERR_DATA (reads) or 0 (writes), mem_err<=1 (sticky until reset), -> DONE. Ack on the final cycle wins over timeout.
- Undefined: no counter, mem_err tied 0, ACCESS waits indefinitely.

## Test plan
- Reset mid-ACCESS: assert reset with dmem_req=1 -> dmem_req=0 same cycle, all WB_*=0, state IDLE; later ack produces no WB update.
- ALU op (RegWrite=1, ALUresult=0x1234, dest=5) -> next edge WB_ALUresult_Out=0x1234, WB_WriteRegister_Out=5, stall never high.
- Load addr 0x40, ack after 3 ACCESS cycles with rdata=0xCAFEF00D -> stall high 4 cycles, dmem_req high 3 cycles, WB_ReadData_Out=0xCAFEF00D, WB_MemtoReg_Out=1.
- Store addr 0x80 data 0x55AA55AA, read+write both set -> dmem_we=1, dmem_wdata=0x55AA55AA, WB_ReadData_Out=0.
- beq Zero=1 -> PCSrc=1; bne Zero=1 -> PCSrc=0; Branch=11 -> PCSrc=0.
- MEM_TIMEOUT_EN, load never acked -> after 16 ACCESS cycles dmem_req=0, WB_ReadData_Out=0xDEADBEEF, mem_err=1 held until reset.
